bsync_tracker: RTL and testbench
================================

// Module: bsync_tracker
// PURPOSE
// - Upstream stage of each per-channel trigger phase adjuster in axi_adf4030. Synchronises the external BSYNC
//   reference, measures its period in clk cycles and declares lock after consistent periods.
// - Drives bsync_ready, the measured bsync_ratio and a delayed, BSYNC-aligned trigger into the channel stage.
// PARAMETERS
// - LOCK_COUNT  4      consecutive in-tolerance periods required to lock (1..15)
// - MISS_LIMIT  2      consecutive out-of-tolerance periods that drop lock (1..15)
// - TOL         2      allowed |period - reference period| in clk cycles
// - TRIG_WIDTH  4      trigger pulse high time in clk cycles (>=1)
// PORTS
// - clk          in   1   single clock; all logic on posedge
// - rst          in   1   reset; synchronous, active-high
// - bsync_in     in   1   external BSYNC reference, asynchronous to clk
// - enable       in   1   tracker enable; low forces IDLE
// - bsync_delay  in   5   trigger delay after BSYNC edge, clk cycles
// - bsync_ready  out  1   high while LOCKED
// - bsync_ratio  out  16  locked BSYNC period in clk cycles; 0 when not locked
// - trigger      out  1   TRIG_WIDTH-cycle pulse per BSYNC edge while LOCKED
// - lock_lost    out  1   sticky; set on LOCKED->ACQUIRE, cleared by rst or enable low
// BEHAVIOUR
// - Reset/enable low: state IDLE; bsync_ready=0, bsync_ratio=0, trigger=0, lock_lost=0; all counters 0.
//   Synchroniser flops are not cleared by enable. Reset mid-operation aborts any pulse immediately.
// - Front end: 2-FF synchroniser, then a registered rising-edge detect, edge_det. Cycle E is the cycle
//   edge_det is high.
// - Period counter pcnt, 16 bit: on edge_det, period=pcnt and pcnt<=1; else pcnt<=pcnt+1, saturating at 0xFFFF.
// - have_prev: cleared on entry to ACQUIRE; set by first edge. Edges with have_prev=0 only restart pcnt.
// - FSM states: IDLE, ACQUIRE, LOCKED.
// - IDLE->ACQUIRE: transition when enable=1.
// - ACQUIRE, edge with have_prev=1:
//   - |period-ref|<=TOL: match_cnt++. Else match_cnt<=0.
//   - ref<=period on every such edge.
//   - match_cnt reaching LOCK_COUNT -> LOCKED, bsync_ratio<=period, and bsync_ready=1 from the next cycle.
// - LOCKED, edge:
//   - |period-bsync_ratio|<=TOL: miss_cnt<=0.
//   - Else miss_cnt++. Reaching MISS_LIMIT -> ACQUIRE.
//   - bsync_ratio is not updated while locked.
// - LOCKED timeout: pcnt reaching bsync_ratio+TOL+MISS_LIMIT*bsync_ratio without an edge -> ACQUIRE.
//   Compute in 18 bits, saturating.
// - On LOCKED->ACQUIRE: bsync_ready=0, bsync_ratio=0, lock_lost=1, and any pending or active trigger is cancelled.
// - Trigger: in LOCKED, on each edge_det, load dcnt=bsync_delay.
//   - The edge that causes the lock does not trigger.
//   - trigger rises at cycle E+1+bsync_delay and stays high TRIG_WIDTH cycles.
//   - bsync_delay is sampled at E; later changes affect only the next edge.
// - Simultaneous events:
//   - New edge during pending delay: restart, latest edge wins.
//   - New edge during an active pulse: the pulse is truncated and the new delay starts.
//   - enable falling has priority over everything.
//   - An edge that is also the MISS_LIMIT-th miss triggers nothing.
// - Width: period and ref are 16-bit unsigned; differences are taken as 17-bit signed, and the absolute value is compared.
// STRUCTURE
// - adf4030_pkg: bsync_state_t enum {IDLE, ACQUIRE, LOCKED}; BSYNC_CNT_W=16; BSYNC_DLY_W=5.
// - One sub-module: bsync_edge_sync. It contains the 2-FF synchroniser plus registered rising-edge detect,
//   outputs edge_det, and is reusable for the SYSREF input.
// - Top holds the FSM, period/match/miss counters, and the trigger delay/width counters.
// TESTING
// - Lock: period 100, bsync_delay=0.
//   -> bsync_ready=1 on the cycle after the 5th edge (LOCK_COUNT=4), bsync_ratio=100, trigger rises at E+1 on later edges.
// - Delay: bsync_delay=31, TRIG_WIDTH=4 -> trigger high at E+32..E+35. Changing delay mid-wait has no effect until the next edge.
// - Jitter: periods 100,102,98,101 -> stays locked. Periods 100,104,105 -> lock drops after the 2nd miss, lock_lost=1, bsync_ratio=0.
// - Loss: stop bsync_in while locked at period 100 -> ACQUIRE at pcnt=302, trigger cancelled, bsync_ready=0.
// - Enable low mid-pulse -> trigger=0 and bsync_ready=0 next cycle. Re-enable -> relock needs 5 fresh edges.
// - rst asserted mid-delay -> all outputs 0 next cycle. No trigger emitted afterwards until relock.

Source files
------------

// File: rtl/adf4030_pkg.sv
// Shared types and widths for the ADF4030 BSYNC/trigger datapath.
// Includes the period-difference helper used by the tracker.
package adf4030_pkg;

   localparam int BSYNC_CNT_W = 16;
   localparam int BSYNC_DLY_W = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } bsync_state_t;

   function automatic logic [BSYNC_CNT_W:0] abs_diff(
      input logic [BSYNC_CNT_W-1:0] a,
      input logic [BSYNC_CNT_W-1:0] b
   );
      logic signed [BSYNC_CNT_W:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      return d[BSYNC_CNT_W] ? -d : d;
   endfunction

endpackage

// File: rtl/bsync_edge_sync.sv
// 2-FF synchroniser plus registered rising-edge detect.
// Generic enough to serve BSYNC or SYSREF inputs.
module bsync_edge_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_edge
);

   logic r_s1;
   logic r_s2;
   logic r_s3;
   logic r_edge;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1   <= 1'b0;
         r_s2   <= 1'b0;
         r_s3   <= 1'b0;
         r_edge <= 1'b0;
      end else begin
         r_s1   <= i_async;
         r_s2   <= r_s1;
         r_s3   <= r_s2;
         r_edge <= r_s2 & ~r_s3;
      end
   end

   assign o_edge = r_edge;

endmodule

// File: rtl/bsync_tracker.sv
// BSYNC period tracker: measures period, locks, and emits a
// delayed BSYNC-aligned trigger pulse to the channel stage.
module bsync_tracker
   import adf4030_pkg::*;
#(
   parameter int LOCK_COUNT = 4,
   parameter int MISS_LIMIT = 2,
   parameter int TOL        = 2,
   parameter int TRIG_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   bsync_in,
   input  logic                   enable,
   input  logic [BSYNC_DLY_W-1:0] bsync_delay,
   output logic                   bsync_ready,
   output logic [BSYNC_CNT_W-1:0] bsync_ratio,
   output logic                   trigger,
   output logic                   lock_lost
);

   localparam int CW = BSYNC_CNT_W;
   localparam int DW = BSYNC_DLY_W;
   localparam int MW = 4;
   localparam int WW = $clog2(TRIG_WIDTH + 1);

   bsync_state_t r_state, w_state_nxt;
   logic [CW-1:0] r_pcnt, w_pcnt_nxt;
   logic [CW-1:0] r_ref, w_ref_nxt;
   logic [CW-1:0] r_ratio, w_ratio_nxt;
   logic [MW-1:0] r_match, w_match_nxt;
   logic [MW-1:0] r_miss, w_miss_nxt;
   logic [DW-1:0] r_dcnt, w_dcnt_nxt;
   logic [WW-1:0] r_wcnt, w_wcnt_nxt;
   logic          r_have, w_have_nxt;
   logic          r_lost, w_lost_nxt;
   logic          r_pend, w_pend_nxt;

   logic          w_edge;
   logic          w_fire;
   logic          w_drop;
   logic [CW:0]   w_diff_ref;
   logic [CW:0]   w_diff_rat;
   logic          w_ref_ok;
   logic          w_rat_ok;
   logic [21:0]   w_lim_full;
   logic [17:0]   w_lim;
   logic          w_tmo;

   bsync_edge_sync u_sync (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_async (bsync_in),
      .o_edge  (w_edge)
   );

   assign w_diff_ref = abs_diff(r_pcnt, r_ref);
   assign w_diff_rat = abs_diff(r_pcnt, r_ratio);
   // A cleared ref means this is the first measured period of the run
   assign w_ref_ok   = (r_ref == '0) ||
                       (w_diff_ref <= (CW+1)'(TOL));
   assign w_rat_ok   = (w_diff_rat <= (CW+1)'(TOL));

   assign w_lim_full = 22'(r_ratio) * 22'(MISS_LIMIT + 1)
                     + 22'(TOL);
   assign w_lim      = (|w_lim_full[21:18]) ? 18'h3FFFF
                                            : w_lim_full[17:0];
   assign w_tmo      = ({2'b00, r_pcnt} >= w_lim);

   always_comb begin
      w_state_nxt = r_state;
      w_pcnt_nxt  = (r_pcnt == '1) ? r_pcnt : r_pcnt + CW'(1);
      w_ref_nxt   = r_ref;
      w_ratio_nxt = r_ratio;
      w_match_nxt = r_match;
      w_miss_nxt  = r_miss;
      w_dcnt_nxt  = r_dcnt;
      w_wcnt_nxt  = (r_wcnt != '0) ? r_wcnt - WW'(1) : '0;
      w_have_nxt  = r_have;
      w_lost_nxt  = r_lost;
      w_pend_nxt  = r_pend;
      w_fire      = 1'b0;
      w_drop      = 1'b0;

      if (r_pend) begin
         if (r_dcnt == DW'(1)) begin
            w_pend_nxt = 1'b0;
            w_wcnt_nxt = WW'(TRIG_WIDTH);
         end else begin
            w_dcnt_nxt = r_dcnt - DW'(1);
         end
      end

      unique case (r_state)
         IDLE: begin
            w_pcnt_nxt = '0;
            if (enable) begin
               w_state_nxt = ACQUIRE;
               w_have_nxt  = 1'b0;
               w_ref_nxt   = '0;
               w_match_nxt = '0;
               w_miss_nxt  = '0;
            end
         end
         ACQUIRE: begin
            if (w_edge) begin
               w_pcnt_nxt = CW'(1);
               w_have_nxt = 1'b1;
               if (r_have) begin
                  w_ref_nxt = r_pcnt;
                  if (!w_ref_ok) begin
                     w_match_nxt = '0;
                  end else if (r_match == MW'(LOCK_COUNT - 1)) begin
                     w_state_nxt = LOCKED;
                     w_ratio_nxt = r_pcnt;
                     w_match_nxt = '0;
                     w_miss_nxt  = '0;
                  end else begin
                     w_match_nxt = r_match + MW'(1);
                  end
               end
            end
         end
         LOCKED: begin
            if (w_edge) begin
               w_pcnt_nxt = CW'(1);
               if (w_rat_ok) begin
                  w_miss_nxt = '0;
                  w_fire     = 1'b1;
               end else if (r_miss == MW'(MISS_LIMIT - 1)) begin
                  w_drop = 1'b1;
               end else begin
                  w_miss_nxt = r_miss + MW'(1);
                  w_fire     = 1'b1;
               end
            end else if (w_tmo) begin
               w_drop = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      // Latest edge wins: any pending delay or live pulse restarts
      if (w_fire) begin
         if (bsync_delay == '0) begin
            w_pend_nxt = 1'b0;
            w_wcnt_nxt = WW'(TRIG_WIDTH);
         end else begin
            w_pend_nxt = 1'b1;
            w_dcnt_nxt = bsync_delay;
            w_wcnt_nxt = '0;
         end
      end

      if (w_drop) begin
         w_state_nxt = ACQUIRE;
         w_have_nxt  = 1'b0;
         w_ref_nxt   = '0;
         w_match_nxt = '0;
         w_miss_nxt  = '0;
         w_ratio_nxt = '0;
         w_lost_nxt  = 1'b1;
         w_pend_nxt  = 1'b0;
         w_dcnt_nxt  = '0;
         w_wcnt_nxt  = '0;
      end

      if (!enable) begin
         w_state_nxt = IDLE;
         w_pcnt_nxt  = '0;
         w_have_nxt  = 1'b0;
         w_ref_nxt   = '0;
         w_match_nxt = '0;
         w_miss_nxt  = '0;
         w_ratio_nxt = '0;
         w_lost_nxt  = 1'b0;
         w_pend_nxt  = 1'b0;
         w_dcnt_nxt  = '0;
         w_wcnt_nxt  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_pcnt  <= '0;
         r_ref   <= '0;
         r_ratio <= '0;
         r_match <= '0;
         r_miss  <= '0;
         r_dcnt  <= '0;
         r_wcnt  <= '0;
         r_have  <= 1'b0;
         r_lost  <= 1'b0;
         r_pend  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pcnt  <= w_pcnt_nxt;
         r_ref   <= w_ref_nxt;
         r_ratio <= w_ratio_nxt;
         r_match <= w_match_nxt;
         r_miss  <= w_miss_nxt;
         r_dcnt  <= w_dcnt_nxt;
         r_wcnt  <= w_wcnt_nxt;
         r_have  <= w_have_nxt;
         r_lost  <= w_lost_nxt;
         r_pend  <= w_pend_nxt;
      end
   end

   assign bsync_ready = (r_state == LOCKED);
   assign bsync_ratio = r_ratio;
   assign trigger     = (r_wcnt != '0);
   assign lock_lost   = r_lost;

endmodule

// File: tb/tb_bsync_tracker.sv
// Self-checking bench for bsync_tracker: edge-time model plus
// directed lock, delay, jitter, loss, enable and reset scenarios.
module tb_bsync_tracker;

   localparam int LOCK_COUNT = 4;
   localparam int MISS_LIMIT = 2;
   localparam int TOL        = 2;
   localparam int TRIG_WIDTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bsync_in = 1'b0;
   logic        enable = 1'b0;
   logic [4:0]  bsync_delay = 5'd0;
   logic        bsync_ready;
   logic [15:0] bsync_ratio;
   logic        trigger;
   logic        lock_lost;

   bsync_tracker #(
      .LOCK_COUNT (LOCK_COUNT),
      .MISS_LIMIT (MISS_LIMIT),
      .TOL        (TOL),
      .TRIG_WIDTH (TRIG_WIDTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bsync_in    (bsync_in),
      .enable      (enable),
      .bsync_delay (bsync_delay),
      .bsync_ready (bsync_ready),
      .bsync_ratio (bsync_ratio),
      .trigger     (trigger),
      .lock_lost   (lock_lost)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n = 0;

   task automatic chk(input string nm, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %0d expected %0d",
                  nm, n, got, exp);
      end
   endtask

   // Model: lock state as plain numbers, triggers as cycle windows
   localparam int M_IDLE = 0;
   localparam int M_ACQ  = 1;
   localparam int M_LCK  = 2;

   int   m_st = M_IDLE;
   int   m_last, m_ref, m_match, m_miss, m_ratio;
   int   m_ts = 1;
   int   m_te = 0;
   bit   m_have, m_lost, m_edge, m_valid;
   bit [3:0] m_h;

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic m_zero();
      m_have = 0; m_ref = 0; m_match = 0; m_miss = 0;
      m_ratio = 0; m_lost = 0; m_ts = 1; m_te = 0;
   endtask

   task automatic m_drop();
      m_st = M_ACQ; m_have = 0; m_ref = 0; m_match = 0;
      m_miss = 0; m_ratio = 0; m_lost = 1; m_ts = 1; m_te = 0;
   endtask

   task automatic m_fire(input int c);
      m_ts = c + 1 + int'(bsync_delay);
      m_te = m_ts + TRIG_WIDTH - 1;
   endtask

   always @(posedge clk) begin : model
      int c, p, lim;
      n = n + 1;
      c = n - 1;
      if (rst) begin
         m_st = M_IDLE; m_zero(); m_h = '0; m_edge = 0; m_valid = 1;
      end else begin
         if (!enable) begin
            m_st = M_IDLE; m_zero();
         end else if (m_st == M_IDLE) begin
            m_st = M_ACQ; m_have = 0; m_ref = 0; m_match = 0; m_miss = 0;
         end else if (m_st == M_ACQ) begin
            if (m_edge) begin
               if (m_have) begin
                  p = sat(c - m_last, 65535);
                  if (m_ref == 0 || iabs(p - m_ref) <= TOL) m_match++;
                  else m_match = 0;
                  m_ref = p;
                  if (m_match >= LOCK_COUNT) begin
                     m_st = M_LCK; m_ratio = p; m_match = 0; m_miss = 0;
                  end
               end
               m_have = 1;
               m_last = c;
            end
         end else begin
            lim = sat(m_ratio * (MISS_LIMIT + 1) + TOL, 262143);
            if (m_edge) begin
               p = sat(c - m_last, 65535);
               m_last = c;
               if (iabs(p - m_ratio) <= TOL) begin
                  m_miss = 0; m_fire(c);
               end else if (m_miss + 1 >= MISS_LIMIT) begin
                  m_drop();
               end else begin
                  m_miss++; m_fire(c);
               end
            end else if (sat(c - m_last, 65535) >= lim) begin
               m_drop();
            end
         end
         m_h = {m_h[2:0], bsync_in};
         m_edge = m_h[2] & ~m_h[3];
      end
   end

   int  rdy_rise, rdy_fall, trg_rise, trg_w, trg_run, trg_cnt;
   bit  p_rdy, p_trg;

   always @(negedge clk) begin
      if (m_valid) begin
         chk("ready", int'(bsync_ready), int'(m_st == M_LCK));
         chk("ratio", int'(bsync_ratio), m_ratio);
         chk("trigger", int'(trigger), int'(n >= m_ts && n <= m_te));
         chk("lock_lost", int'(lock_lost), int'(m_lost));
      end
      if (bsync_ready && !p_rdy) rdy_rise = n;
      if (!bsync_ready && p_rdy) rdy_fall = n;
      if (trigger && !p_trg) trg_rise = n;
      if (trigger) begin
         trg_run++; trg_cnt++;
      end else if (p_trg) begin
         trg_w = trg_run; trg_run = 0;
      end
      p_rdy = bsync_ready;
      p_trg = trigger;
   end

   task automatic tick(input int k);
      repeat (k) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic gap(input int p);
      bsync_in = 1'b1;
      tick(p / 2);
      bsync_in = 1'b0;
      tick(p - p / 2);
   endtask

   int t0, tc0;

   initial begin
      tick(3);
      chk("rst_ready", int'(bsync_ready), 0);
      chk("rst_ratio", int'(bsync_ratio), 0);
      chk("rst_trig", int'(trigger), 0);
      rst = 1'b0;
      enable = 1'b1;
      tick(2);

      repeat (4) gap(100);
      t0 = n; gap(100);
      chk("lock_lat", rdy_rise - t0, 4);
      chk("lock_ratio", int'(bsync_ratio), 100);
      t0 = n; gap(100);
      chk("trig_d0_lat", trg_rise - t0, 4);
      chk("trig_d0_w", trg_w, TRIG_WIDTH);

      bsync_delay = 5'd31;
      t0 = n; bsync_in = 1'b1; tick(10);
      bsync_delay = 5'd5;
      tick(40); bsync_in = 1'b0; tick(50);
      chk("trig_d31_lat", trg_rise - t0, 35);
      chk("trig_d31_w", trg_w, TRIG_WIDTH);
      t0 = n; gap(100);
      chk("trig_d5_lat", trg_rise - t0, 9);
      bsync_delay = 5'd0;

      gap(100); gap(102); gap(98); gap(101); gap(100);
      chk("jit_ready", int'(bsync_ready), 1);
      chk("jit_lost", int'(lock_lost), 0);

      gap(104); gap(105);
      t0 = n; gap(50);
      chk("drop_lat", rdy_fall - t0, 4);
      chk("drop_lost", int'(lock_lost), 1);
      chk("drop_ratio", int'(bsync_ratio), 0);

      repeat (5) gap(100);
      chk("relock", int'(bsync_ready), 1);
      chk("sticky", int'(lock_lost), 1);

      t0 = n; bsync_in = 1'b1; tick(50);
      bsync_in = 1'b0; tick(400);
      chk("loss_lat", rdy_fall - t0, 306);
      chk("loss_ready", int'(bsync_ready), 0);
      chk("loss_trig", int'(trigger), 0);

      repeat (5) gap(100);
      t0 = n; bsync_in = 1'b1; tick(4);
      @(negedge clk);
      chk("mid_pulse", int'(trigger), 1);
      enable = 1'b0;
      @(negedge clk);
      chk("en_trig", int'(trigger), 0);
      chk("en_ready", int'(bsync_ready), 0);
      chk("en_lost", int'(lock_lost), 0);
      bsync_in = 1'b0;
      tick(20);
      enable = 1'b1;
      repeat (4) gap(100);
      chk("reen_4", int'(bsync_ready), 0);
      t0 = n; gap(100);
      chk("reen_lat", rdy_rise - t0, 4);

      bsync_delay = 5'd31;
      t0 = n; bsync_in = 1'b1; tick(10);
      rst = 1'b1; tick(1);
      chk("rst_mid_ready", int'(bsync_ready), 0);
      chk("rst_mid_ratio", int'(bsync_ratio), 0);
      chk("rst_mid_trig", int'(trigger), 0);
      rst = 1'b0;
      tc0 = trg_cnt;
      tick(40); bsync_in = 1'b0; tick(50);
      repeat (3) gap(100);
      chk("rst_no_trig", trg_cnt - tc0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
